// File: rtl/parity_sched.sv
// parity_sched: round-robin shares one byte-wide xorpar unit between NREQ requesters,
// folding each accepted word one byte per cycle into a registered parity result.
module xorpar (
  input  logic [7:0] d,
  output logic       p
);
  assign p = ^d;
endmodule

module parity_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  res_parity,
  output logic [IDW-1:0]        res_id,
  output logic                  busy
);
  localparam int NB = WIDTH / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;

  if (WIDTH % 8 != 0 || WIDTH < 8) begin : g_bad_width
    $error("parity_sched: WIDTH must be a positive multiple of 8");
  end
  if ((2 ** IDW) < NREQ || NREQ < 2) begin : g_bad_idw
    $error("parity_sched: need NREQ >= 2 and 2**IDW >= NREQ");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             acc_q, acc_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [IDW-1:0]   last_q, last_d;
  logic [IDW-1:0]   res_id_q, res_id_d;
  logic             res_parity_q, res_parity_d;
  logic             byte_par;
  logic [IDW-1:0]   win;
  logic             any;
  int               idx;

  xorpar u_xorpar (.d(shift_q[7:0]), .p(byte_par));

  // Search starts just after the last grant so every requester gets a turn.
  always_comb begin
    win = '0;
    any = 1'b0;
    idx = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_q) + k) % NREQ;
      if (!any && req_valid[idx]) begin
        any = 1'b1;
        win = IDW'(idx);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    id_d         = id_q;
    last_d       = last_q;
    res_id_d     = res_id_q;
    res_parity_d = res_parity_q;
    case (state_q)
      IDLE: if (any) begin
        shift_d = req_data[int'(win)*WIDTH +: WIDTH];
        id_d    = win;
        last_d  = win;
        acc_d   = 1'b0;
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        acc_d   = acc_q ^ byte_par;
        shift_d = shift_q >> 8;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(NB - 1)) begin
          state_d      = DONE;
          res_parity_d = acc_q ^ byte_par;
          res_id_d     = id_q;
        end
      end
      DONE: state_d = res_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      cnt_q        <= '0;
      acc_q        <= 1'b0;
      id_q         <= '0;
      last_q       <= IDW'(NREQ - 1);
      res_id_q     <= '0;
      res_parity_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      id_q         <= id_d;
      last_q       <= last_d;
      res_id_q     <= res_id_d;
      res_parity_q <= res_parity_d;
    end
  end

  assign req_ready  = (state_q == IDLE && any) ? (NREQ'(1) << win) : '0;
  assign res_valid  = state_q == DONE;
  assign busy       = state_q != IDLE;
  assign res_parity = res_parity_q;
  assign res_id     = res_id_q;
endmodule

// File: tb/tb_parity_sched.sv
// tb_parity_sched: random and directed traffic against a cycle-level reference model
// (pending result with countdown, round-robin winner search, word parity via ^).
module tb_parity_sched;
  localparam int NREQ = 4, WIDTH = 32, IDW = 2, NB = WIDTH / 8;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ*WIDTH-1:0] req_data = '0;
  logic [NREQ-1:0]       req_ready;
  logic                  res_valid;
  logic                  res_ready = 1'b0;
  logic                  res_parity;
  logic [IDW-1:0]        res_id;
  logic                  busy;

  int checks = 0, errors = 0;
  int m_last, m_t, m_id, nacc;
  logic m_pend, m_par;
  int grants[$];

  parity_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .res_valid(res_valid), .res_ready(res_ready),
    .res_parity(res_parity), .res_id(res_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = 1'b0;
    m_t    = 0;
    m_last = NREQ - 1;
  endtask

  task automatic step(input logic [NREQ-1:0] v, input logic [NREQ*WIDTH-1:0] d, input logic rr);
    int w;
    logic [NREQ-1:0] exp_rdy;
    logic [WIDTH-1:0] word;
    @(negedge clk);
    req_valid = v;
    req_data  = d;
    res_ready = rr;
    #1;
    w = -1;
    for (int k = 1; k <= NREQ; k++)
      if (w < 0 && v[(m_last + k) % NREQ]) w = (m_last + k) % NREQ;
    exp_rdy = (!m_pend && w >= 0) ? NREQ'(1 << w) : '0;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("res_valid", 32'(res_valid), 32'(m_pend && m_t == 0));
    chk("busy", 32'(busy), 32'(m_pend));
    if (m_pend && m_t == 0) begin
      chk("res_parity", 32'(res_parity), 32'(m_par));
      chk("res_id", 32'(res_id), 32'(m_id));
    end
    for (int i = 0; i < NREQ; i++) if (req_ready[i]) grants.push_back(i);
    if (!m_pend && w >= 0) begin
      word   = d[w*WIDTH +: WIDTH];
      m_pend = 1'b1;
      m_t    = NB;
      m_par  = ^word;
      m_id   = w;
      m_last = w;
      nacc++;
    end else if (m_pend && m_t > 0) m_t--;
    else if (m_pend && rr) m_pend = 1'b0;
  endtask

  task automatic rst_pulse();
    @(negedge clk);
    req_valid = '0;
    res_ready = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_res_parity", 32'(res_parity), 0);
    chk("rst_res_id", 32'(res_id), 0);
    chk("rst_busy", 32'(busy), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic idle(input int n, input logic rr);
    for (int i = 0; i < n; i++) step('0, '0, rr);
  endtask

  function automatic logic [NREQ*WIDTH-1:0] pack(input logic [31:0] a, b, c, e);
    return {e, c, b, a};
  endfunction

  initial begin
    logic [NREQ*WIDTH-1:0] rd;
    int cyc;
    model_reset();
    nacc = 0;
    #3;
    chk("init_res_valid", 32'(res_valid), 0);
    chk("init_busy", 32'(busy), 0);
    chk("init_res_parity", 32'(res_parity), 0);
    chk("init_res_id", 32'(res_id), 0);
    @(negedge clk);
    rst = 1'b0;
    // single word from req0, then req2 all-ones and top-bit-only words
    step(4'b0001, pack(32'h1, 0, 0, 0), 1'b1);
    idle(6, 1'b1);
    step(4'b0100, pack(0, 0, 32'hFFFF_FFFF, 0), 1'b1);
    idle(6, 1'b1);
    step(4'b0100, pack(0, 0, 32'h8000_0000, 0), 1'b1);
    idle(6, 1'b1);
    // reset while req1 is in flight: no result, then req0 wins
    step(4'b0010, pack(0, 32'h1, 0, 0), 1'b1);
    step('0, '0, 1'b1);
    rst_pulse();
    idle(3, 1'b1);
    step(4'b0011, pack(32'h3, 32'h1, 0, 0), 1'b1);
    idle(6, 1'b1);
    rst_pulse();
    // all requesting: 0,1,2,3,0 at six-cycle spacing
    grants.delete();
    for (int i = 0; i < 5 * (NB + 2); i++) step(4'b1111, pack(32'h1, 32'h3, 32'h7, 32'hF), 1'b1);
    chk("rr_count", 32'(grants.size()), 5);
    for (int i = 0; i < 5 && i < grants.size(); i++) chk("rr_order", 32'(grants[i]), 32'(i % NREQ));
    idle(6, 1'b1);
    // backpressure in DONE
    step(4'b1000, pack(0, 0, 0, 32'h0000_0101), 1'b1);
    idle(NB + 5, 1'b0);
    idle(3, 1'b1);
    // random traffic
    nacc = 0;
    cyc = 0;
    while (nacc < 1000 && cyc < 60000) begin
      for (int i = 0; i < NREQ; i++) rd[i*WIDTH +: WIDTH] = $urandom;
      step(NREQ'($urandom), rd, 1'($urandom));
      cyc++;
    end
    chk("rand_accepts", 32'(nacc >= 1000), 1);
    idle(8, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
